// File: rtl/tamaguchi_pkg.sv
`default_nettype none
// ============================================================================
// tamaguchi_pkg : shared constants, button indices and speed FSM encoding
// Rev 1.0
// ============================================================================
package tamaguchi_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;

    localparam int BTN_JUGAR  = 0;
    localparam int BTN_DORMIR = 1;
    localparam int BTN_COMER  = 2;
    localparam int BTN_TEST   = 3;
    localparam int BTN_TIME   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } speed_state_e;

    function automatic int speed_width(input int n_speeds);
        return (n_speeds > 1) ? $clog2(n_speeds) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tamaguchi_input_timebase_if.sv
`default_nettype none
// ============================================================================
// tamaguchi_input_timebase_if : raw pins in, conditioned buttons and time base out
// Rev 1.0
// ============================================================================
interface tamaguchi_input_timebase_if
    import tamaguchi_pkg::*;
#(
    parameter int N_BTN    = 5,
    parameter int N_SPEEDS = 4
) ();
    localparam int c_spd_w = speed_width(N_SPEEDS);

    logic [N_BTN-1:0]   btn_raw;
    logic [N_BTN-1:0]   btn_level;
    logic [N_BTN-1:0]   btn_press;
    logic [N_BTN-1:0]   btn_release;
    logic [N_BTN-1:0]   btn_long;
    logic [c_spd_w-1:0] speed;
    logic               tick_sec;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_long, speed, tick_sec
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_long, speed, tick_sec
    );
endinterface
`default_nettype wire

// File: rtl/canal_boton.sv
`default_nettype none
// ============================================================================
// canal_boton : one button channel (sync, debounce, edges, long press)
// Rev 1.0
// ============================================================================
module canal_boton #(
    parameter bit ACTIVE_LOW        = 1'b0,
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic press_evt_o,
    output logic release_evt_o,
    output logic long_evt_o
);
    localparam int c_deb_w  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_hold_w = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(LONG_PRESS_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_fire = c_hold_w'(LONG_PRESS_CYCLES - 1);

    logic                sync1_q, sync2_q;
    logic                level_q, level_d;
    logic [c_deb_w-1:0]  deb_cnt_q, deb_cnt_d;
    logic [c_hold_w-1:0] hold_q, hold_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;
    logic                w_norm;
    logic                w_flip;

    always_comb begin
        w_norm    = sync2_q ^ ACTIVE_LOW;
        w_flip    = (w_norm != level_q) && (deb_cnt_q == c_deb_last);
        deb_cnt_d = ((w_norm == level_q) || w_flip) ? '0 : deb_cnt_q + 1'b1;
        level_d   = level_q ^ w_flip;
        press_d   = w_flip & ~level_q;
        release_d = w_flip & level_q;
        long_d    = level_q && (hold_q == c_hold_fire);
        // Saturation keeps btn_long from repeating while the hold continues.
        if (!level_q) begin
            hold_d = '0;
        end else if (hold_q == c_hold_max) begin
            hold_d = hold_q;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= ACTIVE_LOW;
            sync2_q   <= ACTIVE_LOW;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level_o       = level_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign long_o        = long_q;
    assign press_evt_o   = press_d;
    assign release_evt_o = release_d;
    assign long_evt_o    = long_d;
endmodule
`default_nettype wire

// File: rtl/tamaguchi_input_timebase.sv
`default_nettype none
// ============================================================================
// tamaguchi_input_timebase : N button channels plus accelerated game-second tick
// Rev 1.0
// ============================================================================
module tamaguchi_input_timebase
    import tamaguchi_pkg::*;
#(
    parameter int               CLK_HZ            = DEFAULT_CLK_HZ,
    parameter int               N_BTN             = 5,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK   = 5'b11000,
    parameter int               DEBOUNCE_CYCLES   = 500_000,
    parameter int               LONG_PRESS_CYCLES = 100_000_000,
    parameter int               TIME_BTN          = BTN_TIME,
    parameter int               N_SPEEDS          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    tamaguchi_input_timebase_if.slave    bus_io
);
    localparam int c_spd_w = speed_width(N_SPEEDS);
    localparam int c_cnt_w = $clog2(CLK_HZ);

    logic [N_BTN-1:0] w_level, w_press, w_release, w_long;
    logic [N_BTN-1:0] w_press_evt, w_release_evt, w_long_evt;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            canal_boton #(
                .ACTIVE_LOW        (ACTIVE_LOW_MASK[i]),
                .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
                .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
            ) u_chan (
                .clk           (clk),
                .rst           (rst),
                .raw_i         (bus_io.btn_raw[i]),
                .level_o       (w_level[i]),
                .press_o       (w_press[i]),
                .release_o     (w_release[i]),
                .long_o        (w_long[i]),
                .press_evt_o   (w_press_evt[i]),
                .release_evt_o (w_release_evt[i]),
                .long_evt_o    (w_long_evt[i])
            );
        end
    endgenerate

    speed_state_e         state_q, state_d;
    logic [c_spd_w-1:0]   speed_q, speed_d, w_speed_inc;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d, w_last;
    logic                 tick_q, tick_d;

    // Channel next-state events let speed change in the same cycle the pulse shows.
    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        w_speed_inc = (speed_q == c_spd_w'(N_SPEEDS - 1)) ? '0 : speed_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (w_press_evt[TIME_BTN]) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (w_long_evt[TIME_BTN]) begin
                    speed_d = '0;
                    state_d = w_release_evt[TIME_BTN] ? ST_IDLE : ST_LONG;
                end else if (w_release_evt[TIME_BTN]) begin
                    speed_d = w_speed_inc;
                    state_d = ST_IDLE;
                end
            end
            ST_LONG: begin
                if (w_release_evt[TIME_BTN]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_last = c_cnt_w'((CLK_HZ >> speed_q) - 1);
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (speed_d != speed_q) begin
            cnt_d = '0;
        end else if (cnt_q == w_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            speed_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign bus_io.btn_level   = w_level;
    assign bus_io.btn_press   = w_press;
    assign bus_io.btn_release = w_release;
    assign bus_io.btn_long    = w_long;
    assign bus_io.speed       = speed_q;
    assign bus_io.tick_sec    = tick_q;
endmodule
`default_nettype wire

// File: tb/tb_tamaguchi_input_timebase.sv
`default_nettype none
// ============================================================================
// tb_tamaguchi_input_timebase : scoreboard bench with a timestamp-based model
// Rev 1.0
// ============================================================================
module tb_tamaguchi_input_timebase;
    localparam int         CLK_HZ = 64;
    localparam int         DEB    = 4;
    localparam int         LONG   = 20;
    localparam int         NSP    = 4;
    localparam int         TB     = 4;
    localparam logic [4:0] MASK   = 5'b11000;
    localparam logic [4:0] IDLE   = MASK;

    typedef struct packed {
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
        logic [4:0] lng;
        logic [1:0] spd;
        logic       tck;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: sync pipe, last DEB normalised samples, press timestamps.
    logic [4:0] m_s1, m_s2, m_lvl;
    logic [3:0] m_win[5];
    int         m_tp[5];
    int         m_n, m_spd, m_tr;
    bit         m_lih;

    tamaguchi_input_timebase_if #(.N_BTN(5), .N_SPEEDS(NSP)) bus();

    tamaguchi_input_timebase #(
        .CLK_HZ            (CLK_HZ),
        .N_BTN             (5),
        .ACTIVE_LOW_MASK   (MASK),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .TIME_BTN          (TB),
        .N_SPEEDS          (NSP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic [4:0] raw, input logic r);
        exp_t       e;
        logic [4:0] norm;
        int         nspd;
        int         per;
        e = '0;
        if (r) begin
            m_s1  = MASK;
            m_s2  = MASK;
            m_lvl = '0;
            for (int c = 0; c < 5; c++) begin
                m_win[c] = '0;
                m_tp[c]  = 0;
            end
            m_n   = 0;
            m_spd = 0;
            m_tr  = 0;
            m_lih = 1'b0;
        end else begin
            m_n++;
            norm = m_s2 ^ MASK;
            for (int c = 0; c < 5; c++) begin
                m_win[c] = {m_win[c][2:0], norm[c]};
                if (m_win[c] == {4{~m_lvl[c]}}) begin
                    e.prs[c] = ~m_lvl[c];
                    e.rel[c] = m_lvl[c];
                end
                if (m_lvl[c] && (m_n - m_tp[c] == LONG)) e.lng[c] = 1'b1;
                if (e.prs[c]) m_tp[c] = m_n;
            end
            m_lvl = m_lvl ^ (e.prs | e.rel);
            m_s2  = m_s1;
            m_s1  = raw;
            nspd  = m_spd;
            if (e.prs[TB]) m_lih = 1'b0;
            if (e.lng[TB]) begin
                nspd  = 0;
                m_lih = 1'b1;
            end
            if (e.rel[TB]) begin
                if (!m_lih) nspd = (m_spd + 1) % NSP;
                m_lih = 1'b0;
            end
            per = CLK_HZ >> m_spd;
            if (nspd != m_spd) begin
                m_spd = nspd;
                m_tr  = m_n;
            end else begin
                e.tck = ((m_n - m_tr) % per == 0);
            end
        end
        e.lvl = m_lvl;
        e.spd = 2'(m_spd);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [4:0] raw, input logic r);
        @(negedge clk);
        bus.btn_raw = raw;
        rst         = r;
        @(posedge clk);
        model_step(raw, r);
    endtask

    task automatic hold(input logic [4:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    // Monitor: every modelled cycle yields one expected output record.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long,
                     bus.speed, bus.tick_sec};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: actual lvl=%b prs=%b rel=%b lng=%b spd=%0d tck=%b, required lvl=%b prs=%b rel=%b lng=%b spd=%0d tck=%b",
                             $time, a.lvl, a.prs, a.rel, a.lng, a.spd, a.tck,
                             e.lvl, e.prs, e.rel, e.lng, e.spd, e.tck);
                end
            end
        end
    end

    initial begin
        logic [4:0] cur;
        int         rem[5];
        logic       r;
        rst         = 1'b1;
        bus.btn_raw = IDLE;
        repeat (3) step(IDLE, 1'b1);
        hold(IDLE, 140);

        // Channel 0 clean press/release, then a 3-cycle glitch.
        hold(IDLE | 5'b00001, 12);
        hold(IDLE, 12);
        hold(IDLE | 5'b00001, 3);
        hold(IDLE, 10);

        // Active-low channel 3 held long enough for a long press.
        hold(IDLE & ~5'b01000, 30);
        hold(IDLE, 15);

        // Four short TIME presses cycle through every speed.
        for (int k = 0; k < 4; k++) begin
            hold(IDLE & ~5'b10000, 8);
            hold(IDLE, 80);
        end

        // Reach speed 2, then a long TIME hold forces speed 0.
        for (int k = 0; k < 2; k++) begin
            hold(IDLE & ~5'b10000, 8);
            hold(IDLE, 40);
        end
        hold(IDLE & ~5'b10000, 30);
        hold(IDLE, 40);

        // Reset in the middle of a channel 1 hold.
        hold(IDLE | 5'b00010, 12);
        step(IDLE | 5'b00010, 1'b1);
        step(IDLE | 5'b00010, 1'b1);
        hold(IDLE | 5'b00010, 15);
        hold(IDLE, 15);

        cur = IDLE;
        for (int c = 0; c < 5; c++) rem[c] = 0;
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < 5; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                         : $urandom_range(4, 40);
                end
                rem[c]--;
            end
            r = ($urandom_range(0, 599) == 0);
            step(cur, r);
        end
        hold(IDLE, 30);

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
